// File: rtl/line_engine_pkg.sv
// Shared definitions for the line-draw engine.
//   - FSM state encoding
//   - frame-buffer address packing widths and color width
//   - abs_diff: magnitude of an 11-bit signed coordinate difference
package line_engine_pkg;

  localparam int X_BITS     = 10;
  localparam int Y_BITS     = 10;
  localparam int COLOR_BITS = 24;
  localparam int DIFF_BITS  = X_BITS + 1;
  localparam int ERR_BITS   = 12;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_SWAP_STEEP = 2'd1,
    ST_SWAP_ORDER = 2'd2,
    ST_DRAW       = 2'd3
  } line_state_t;

  // |a - b| using a signed 11-bit difference; the result always fits 10 bits.
  function automatic logic [X_BITS-1:0] abs_diff(input logic [X_BITS-1:0] a,
                                                 input logic [X_BITS-1:0] b);
    logic signed [DIFF_BITS-1:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    if (d[DIFF_BITS-1]) begin
      abs_diff = X_BITS'(-d);
    end else begin
      abs_diff = X_BITS'(d);
    end
  endfunction

endpackage

// File: rtl/line_param_regs.sv
// Strobe-loaded line parameter registers (x0, y0, x1, y1, color).
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   load_en           high while the engine is idle; gates every strobe
//   point             coordinate value for the x0/y0/x1/y1 strobes
//   color             pixel color, low 24 bits stored
//   *_valid           per-register load strobes; simultaneous strobes all load
//   x0_r..color_r     latched parameters
module line_param_regs
  import line_engine_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_en,
  input  logic [X_BITS-1:0]     point,
  input  logic [31:0]           color,
  input  logic                  color_valid,
  input  logic                  x0_valid,
  input  logic                  y0_valid,
  input  logic                  x1_valid,
  input  logic                  y1_valid,
  output logic [X_BITS-1:0]     x0_r,
  output logic [Y_BITS-1:0]     y0_r,
  output logic [X_BITS-1:0]     x1_r,
  output logic [Y_BITS-1:0]     y1_r,
  output logic [COLOR_BITS-1:0] color_r
);

  // The top color byte is not part of the pixel format.
  logic unused_color_s;
  assign unused_color_s = &{1'b0, color[31:COLOR_BITS]};

  // Parameter register file; loads are ignored while a line is in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x0_r    <= '0;
      y0_r    <= '0;
      x1_r    <= '0;
      y1_r    <= '0;
      color_r <= '0;
    end else if (load_en) begin
      if (x0_valid)    x0_r    <= point;
      if (y0_valid)    y0_r    <= point;
      if (x1_valid)    x1_r    <= point;
      if (y1_valid)    y1_r    <= point;
      if (color_valid) color_r <= color[COLOR_BITS-1:0];
    end
  end

endmodule

// File: rtl/line_engine.sv
// Bresenham line rasterizer with a frame-buffer word-write port.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   line_color/_valid   color load
//   line_point          coordinate for the x0/y0/x1/y1 strobes
//   line_*_valid        coordinate load strobes (honoured only when idle)
//   line_trigger        start drawing the latched line
//   line_ready          engine idle
//   fb_addr/fb_din/fb_we  pixel write, held while fb_ready is low
//   fb_ready            arbiter accepts the pending write
module line_engine
  import line_engine_pkg::*;
#(
  parameter logic [31:0] FB_BASE = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] line_color,
  input  logic [9:0]  line_point,
  input  logic        line_color_valid,
  input  logic        line_x0_valid,
  input  logic        line_y0_valid,
  input  logic        line_x1_valid,
  input  logic        line_y1_valid,
  input  logic        line_trigger,
  output logic        line_ready,
  output logic [31:0] fb_addr,
  output logic [31:0] fb_din,
  output logic [3:0]  fb_we,
  input  logic        fb_ready
);

  line_state_t state_r;

  logic [X_BITS-1:0]     p_x0_s, p_x1_s;
  logic [Y_BITS-1:0]     p_y0_s, p_y1_s;
  logic [COLOR_BITS-1:0] p_color_s;

  // Working endpoints after the steep swap (x/y may be exchanged).
  logic [9:0] ax0_r, ay0_r, ax1_r, ay1_r;
  logic       steep_r;

  // Bresenham state.
  logic [9:0]                 x_r, y_r, x_end_r, dx_r, dy_r;
  logic signed [ERR_BITS-1:0] err_r;
  logic                       ystep_up_r;

  logic       steep_s;
  logic [9:0] ox0_s, oy0_s, ox1_s, oy1_s, odx_s, ody_s;
  logic       oup_s;

  logic signed [ERR_BITS-1:0] e_s, nerr_s;
  logic [9:0]                 nx_s, ny_s;

  line_param_regs u_params (
    .clk         (clk),
    .rst         (rst),
    .load_en     (state_r == ST_IDLE),
    .point       (line_point),
    .color       (line_color),
    .color_valid (line_color_valid),
    .x0_valid    (line_x0_valid),
    .y0_valid    (line_y0_valid),
    .x1_valid    (line_x1_valid),
    .y1_valid    (line_y1_valid),
    .x0_r        (p_x0_s),
    .y0_r        (p_y0_s),
    .x1_r        (p_x1_s),
    .y1_r        (p_y1_s),
    .color_r     (p_color_s)
  );

  // Byte address of a working point; steep lines plot the swapped pair.
  function automatic logic [31:0] pixel_addr(input logic       steep,
                                             input logic [9:0] px,
                                             input logic [9:0] py);
    logic [9:0] ax, ay;
    if (steep) begin
      ax = py;
      ay = px;
    end else begin
      ax = px;
      ay = py;
    end
    pixel_addr = FB_BASE | {10'd0, ay, ax, 2'b00};
  endfunction

  // Steepness test on the latched endpoints.
  always_comb begin
    steep_s = abs_diff(p_y0_s, p_y1_s) > abs_diff(p_x0_s, p_x1_s);
  end

  // Order the working endpoints left-to-right and derive the step terms.
  always_comb begin
    if (ax0_r > ax1_r) begin
      ox0_s = ax1_r;
      oy0_s = ay1_r;
      ox1_s = ax0_r;
      oy1_s = ay0_r;
    end else begin
      ox0_s = ax0_r;
      oy0_s = ay0_r;
      ox1_s = ax1_r;
      oy1_s = ay1_r;
    end
    odx_s = ox1_s - ox0_s;
    ody_s = abs_diff(oy0_s, oy1_s);
    oup_s = (oy0_s < oy1_s);
  end

  // Next Bresenham point, applied when the current pixel retires.
  always_comb begin
    e_s  = err_r - $signed({2'b00, dy_r});
    nx_s = x_r + 10'd1;
    if (e_s[ERR_BITS-1]) begin
      ny_s   = ystep_up_r ? (y_r + 10'd1) : (y_r - 10'd1);
      nerr_s = e_s + $signed({2'b00, dx_r});
    end else begin
      ny_s   = y_r;
      nerr_s = e_s;
    end
  end

  // Control FSM with registered write-port outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      line_ready <= 1'b1;
      fb_we      <= 4'h0;
      fb_addr    <= 32'h0;
      fb_din     <= 32'h0;
      ax0_r      <= 10'd0;
      ay0_r      <= 10'd0;
      ax1_r      <= 10'd0;
      ay1_r      <= 10'd0;
      steep_r    <= 1'b0;
      x_r        <= 10'd0;
      y_r        <= 10'd0;
      x_end_r    <= 10'd0;
      dx_r       <= 10'd0;
      dy_r       <= 10'd0;
      err_r      <= 12'sd0;
      ystep_up_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (line_trigger) begin
            state_r    <= ST_SWAP_STEEP;
            line_ready <= 1'b0;
          end
        end
        ST_SWAP_STEEP: begin
          steep_r <= steep_s;
          if (steep_s) begin
            ax0_r <= p_y0_s;
            ay0_r <= p_x0_s;
            ax1_r <= p_y1_s;
            ay1_r <= p_x1_s;
          end else begin
            ax0_r <= p_x0_s;
            ay0_r <= p_y0_s;
            ax1_r <= p_x1_s;
            ay1_r <= p_y1_s;
          end
          state_r <= ST_SWAP_ORDER;
        end
        ST_SWAP_ORDER: begin
          x_r        <= ox0_s;
          y_r        <= oy0_s;
          x_end_r    <= ox1_s;
          dx_r       <= odx_s;
          dy_r       <= ody_s;
          err_r      <= $signed({2'b00, 1'b0, odx_s[9:1]});
          ystep_up_r <= oup_s;
          state_r    <= ST_DRAW;
        end
        ST_DRAW: begin
          if (fb_we == 4'h0) begin
            // First cycle in DRAW: present the starting pixel.
            fb_we   <= 4'hF;
            fb_addr <= pixel_addr(steep_r, x_r, y_r);
            fb_din  <= {8'h00, p_color_s};
          end else if (fb_ready) begin
            if (x_r == x_end_r) begin
              fb_we      <= 4'h0;
              line_ready <= 1'b1;
              state_r    <= ST_IDLE;
            end else begin
              x_r     <= nx_s;
              y_r     <= ny_s;
              err_r   <= nerr_s;
              fb_addr <= pixel_addr(steep_r, nx_s, ny_s);
            end
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          line_ready <= 1'b1;
          fb_we      <= 4'h0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_line_engine.sv
// Directed testbench for line_engine: stimulus pushes expected pixel writes
// into a scoreboard queue; a negedge monitor compares every presented write.
module tb_line_engine;

  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] line_color;
  logic [9:0]  line_point;
  logic        line_color_valid, line_x0_valid, line_y0_valid;
  logic        line_x1_valid, line_y1_valid, line_trigger;
  logic        line_ready;
  logic [31:0] fb_addr, fb_din;
  logic [3:0]  fb_we;
  logic        fb_ready;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] din;
  } px_t;

  px_t         sb_q[$];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] cur_din  = 32'h0;

  line_engine #(.FB_BASE(BASE)) dut (
    .clk              (clk),
    .rst              (rst),
    .line_color       (line_color),
    .line_point       (line_point),
    .line_color_valid (line_color_valid),
    .line_x0_valid    (line_x0_valid),
    .line_y0_valid    (line_y0_valid),
    .line_x1_valid    (line_x1_valid),
    .line_y1_valid    (line_y1_valid),
    .line_trigger     (line_trigger),
    .line_ready       (line_ready),
    .fb_addr          (fb_addr),
    .fb_din           (fb_din),
    .fb_we            (fb_we),
    .fb_ready         (fb_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every presented write must match the scoreboard head; the head
  // is popped only when the write retires, so stalled cycles check holding.
  always @(negedge clk) begin
    if (!rst && fb_we != 4'h0) begin
      check("fb_we_value", {28'h0, fb_we}, 32'hF);
      if (sb_q.size() == 0) begin
        check("unexpected_write", fb_addr, 32'hFFFF_FFFF);
      end else begin
        check("fb_addr", fb_addr, sb_q[0].addr);
        check("fb_din", fb_din, sb_q[0].din);
        if (fb_ready) void'(sb_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input int which, input logic [9:0] v);
    line_point = v;
    case (which)
      0: line_x0_valid = 1'b1;
      1: line_y0_valid = 1'b1;
      2: line_x1_valid = 1'b1;
      default: line_y1_valid = 1'b1;
    endcase
    tick();
    line_x0_valid = 1'b0;
    line_y0_valid = 1'b0;
    line_x1_valid = 1'b0;
    line_y1_valid = 1'b0;
  endtask

  task automatic set_color(input logic [31:0] c);
    line_color       = c;
    line_color_valid = 1'b1;
    tick();
    line_color_valid = 1'b0;
    cur_din          = {8'h00, c[23:0]};
  endtask

  task automatic load_line(input logic [9:0] x0, input logic [9:0] y0,
                           input logic [9:0] x1, input logic [9:0] y1);
    strobe(0, x0);
    strobe(1, y0);
    strobe(2, x1);
    strobe(3, y1);
  endtask

  task automatic exp_px(input logic [31:0] off);
    sb_q.push_back({BASE + off, cur_din});
  endtask

  // Pulse trigger (any strobes already set up are sampled in the same cycle)
  // and wait for the first write; checks the 3-cycle start latency.
  task automatic trigger_first(input string name);
    int n;
    line_trigger = 1'b1;
    tick();
    line_trigger  = 1'b0;
    line_x0_valid = 1'b0;
    line_y0_valid = 1'b0;
    line_x1_valid = 1'b0;
    line_y1_valid = 1'b0;
    check({name, "_busy"}, {31'h0, line_ready}, 32'h0);
    n = 0;
    while (fb_we != 4'hF && n < 20) begin
      tick();
      n++;
    end
    check({name, "_latency"}, n, 32'd3);
  endtask

  task automatic wait_done(input string name, input int exp_cycles);
    int m;
    m = 0;
    while (!line_ready && m < 200) begin
      tick();
      m++;
    end
    if (exp_cycles >= 0) check({name, "_done_cycles"}, m, exp_cycles);
    check({name, "_ready"}, {31'h0, line_ready}, 32'h1);
    check({name, "_we_idle"}, {28'h0, fb_we}, 32'h0);
    check({name, "_sb_empty"}, sb_q.size(), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    line_color = 32'h0; line_point = 10'd0;
    line_color_valid = 1'b0; line_x0_valid = 1'b0; line_y0_valid = 1'b0;
    line_x1_valid = 1'b0; line_y1_valid = 1'b0; line_trigger = 1'b0;
    fb_ready = 1'b1;
    tick();
    tick();
    check("rst_ready", {31'h0, line_ready}, 32'h1);
    check("rst_we", {28'h0, fb_we}, 32'h0);
    check("rst_addr", fb_addr, 32'h0);
    check("rst_din", fb_din, 32'h0);
    rst = 1'b0;
    tick();

    // Horizontal line (0,0)->(3,0).
    set_color(32'h00FF_0000);
    load_line(10'd0, 10'd0, 10'd3, 10'd0);
    exp_px(32'h0); exp_px(32'h4); exp_px(32'h8); exp_px(32'hC);
    trigger_first("horiz");
    wait_done("horiz", 4);

    // Steep reversed line (1,3)->(0,0).
    set_color(32'hAB12_3456);
    load_line(10'd1, 10'd3, 10'd0, 10'd0);
    exp_px(32'h0); exp_px(32'h1000); exp_px(32'h2004); exp_px(32'h3004);
    trigger_first("steep");
    wait_done("steep", 4);

    // Single pixel with y1 loaded in the trigger cycle.
    set_color(32'h0000_00FF);
    load_line(10'd5, 10'd7, 10'd5, 10'd0);
    exp_px(32'h7014);
    line_point    = 10'd7;
    line_y1_valid = 1'b1;
    trigger_first("single");
    wait_done("single", 1);

    // Diagonal with a 3-cycle stall on the second pixel.
    set_color(32'h0000_FF00);
    load_line(10'd0, 10'd0, 10'd2, 10'd2);
    exp_px(32'h0); exp_px(32'h1004); exp_px(32'h2008);
    trigger_first("diag");
    tick();
    fb_ready = 1'b0;
    repeat (3) tick();
    fb_ready = 1'b1;
    wait_done("diag", -1);

    // Strobe and re-trigger during DRAW are ignored.
    set_color(32'h0012_3456);
    load_line(10'd10, 10'd20, 10'd13, 10'd20);
    exp_px(32'h14028); exp_px(32'h1402C); exp_px(32'h14030); exp_px(32'h14034);
    trigger_first("busy");
    line_point    = 10'd9;
    line_x0_valid = 1'b1;
    line_trigger  = 1'b1;
    tick();
    line_x0_valid = 1'b0;
    line_trigger  = 1'b0;
    wait_done("busy", -1);
    repeat (10) tick();
    check("busy_no_restart", {31'h0, line_ready}, 32'h1);
    // Redraw with no loads: x0 must still be 10.
    exp_px(32'h14028); exp_px(32'h1402C); exp_px(32'h14030); exp_px(32'h14034);
    trigger_first("redraw");
    wait_done("redraw", 4);

    // Reset during the second pixel.
    exp_px(32'h14028); exp_px(32'h1402C); exp_px(32'h14030); exp_px(32'h14034);
    trigger_first("abort");
    tick();
    rst = 1'b1;
    #1;
    check("abort_we", {28'h0, fb_we}, 32'h0);
    check("abort_ready", {31'h0, line_ready}, 32'h1);
    check("abort_addr", fb_addr, 32'h0);
    sb_q.delete();
    tick();
    rst = 1'b0;
    tick();
    cur_din = 32'h0;
    exp_px(32'h0);
    trigger_first("post_rst");
    wait_done("post_rst", 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
